// File: rtl/ifetch_pkg.sv
// Shared types for the instruction-fetch sequencer.
// Optional stall statistics are enabled with IFETCH_STATS_EN.
package ifetch_pkg;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam int INST_BYTES = 4;

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch queue of fetched words with their PCs.
// Pointers carry an extra MSB so full and empty are distinguishable.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  fetch_entry_t i_entry,
    input  logic         i_pop,
    input  logic         i_flush,
    output logic [AW:0]  o_count,
    output logic         o_valid,
    output fetch_entry_t o_head
);

    logic [AW:0]  r_wr;
    logic [AW:0]  r_rd;
    fetch_entry_t r_mem [DEPTH];

    // Flush wins over a same-cycle push so stale responses never land.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr <= '0;
            r_rd <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr[AW-1:0]] <= i_entry;
                r_wr <= r_wr + 1'b1;
            end
            if (i_pop) begin
                r_rd <= r_rd + 1'b1;
            end
        end
    end

    assign o_count = r_wr - r_rd;
    assign o_valid = (r_wr != r_rd);
    assign o_head  = r_mem[r_rd[AW-1:0]];

endmodule

// File: rtl/ifetch_ctrl.sv
// Fetch sequencer: owns the PC, issues imem reads, queues results.
// Define IFETCH_STATS_EN to add the stall_cnt output.
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          FETCH_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
`ifdef IFETCH_STATS_EN
    output logic [31:0] inst_pc,
    output logic [31:0] stall_cnt
`else
    output logic [31:0] inst_pc
`endif
);

    localparam int AW = $clog2(FETCH_DEPTH);
    localparam logic [AW:0] DEPTH_C = FETCH_DEPTH[AW:0];

    fetch_state_e r_state;
    fetch_state_e w_state_nxt;
    logic [31:0]  r_fetch_pc;
    logic [31:0]  r_infl_pc;
    logic         r_inflight;
    logic         r_drop;
    logic [31:0]  w_redir_pc;
    logic [AW:0]  w_count;
    logic [AW:0]  w_used;
    logic         w_credit;
    logic         w_head_valid;
    logic         w_push;
    logic         w_pop;
    fetch_entry_t w_entry;
    fetch_entry_t w_head;

    assign w_redir_pc = redirect_pc & ~32'h3;

    // Queued entries plus the outstanding read may never exceed the depth.
    assign w_used   = w_count + {{AW{1'b0}}, r_inflight};
    assign w_credit = (w_used < DEPTH_C);

    assign imem_req  = (r_state == S_RUN) & ~redirect_valid & w_credit;
    assign imem_addr = r_fetch_pc;

    assign inst_valid = w_head_valid & ~redirect_valid;
    assign inst_data  = w_head.inst;
    assign inst_pc    = w_head.pc;

    assign w_pop   = inst_valid & inst_ready;
    assign w_push  = r_inflight & ~r_drop;
    assign w_entry = '{pc: r_infl_pc, inst: imem_rdata};

    always_comb begin
        w_state_nxt = r_state;
        priority case (1'b1)
            redirect_valid:
                w_state_nxt = S_RUN;
            (r_state == S_BOOT):
                w_state_nxt = S_RUN;
            (r_state == S_RUN) && !w_credit:
                w_state_nxt = S_HOLD;
            (r_state == S_HOLD) && (w_pop || r_inflight):
                w_state_nxt = S_RUN;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_BOOT;
            r_fetch_pc <= RESET_PC;
            r_infl_pc  <= '0;
            r_inflight <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= imem_req;
            r_drop     <= redirect_valid & r_inflight;
            if (imem_req) begin
                r_infl_pc <= r_fetch_pc;
            end
            if (redirect_valid) begin
                r_fetch_pc <= w_redir_pc;
            end else if (imem_req) begin
                r_fetch_pc <= r_fetch_pc + 32'(INST_BYTES);
            end
        end
    end

    ifetch_fifo #(
        .DEPTH (FETCH_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_entry (w_entry),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .o_count (w_count),
        .o_valid (w_head_valid),
        .o_head  (w_head)
    );

`ifdef IFETCH_STATS_EN
    logic [31:0] r_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall <= '0;
        end else if (inst_ready && !inst_valid && !redirect_valid
                     && !(&r_stall)) begin
            r_stall <= r_stall + 1'b1;
        end
    end

    assign stall_cnt = r_stall;
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Scoreboard bench for ifetch_ctrl: expected PC stream restarts on reset/redirect.
// Memory word n holds value n.
module tb_ifetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
`ifdef IFETCH_STATS_EN
    logic [31:0] stall_cnt;
`endif

    int total = 0;
    int bad = 0;
    int occ = 0;
    logic [31:0] exp_q[$];
    logic [31:0] m_exp;

    ifetch_ctrl #(
        .RESET_PC    (RESET_PC),
        .FETCH_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
`ifdef IFETCH_STATS_EN
        .inst_pc        (inst_pc),
        .stall_cnt      (stall_cnt)
`else
        .inst_pc        (inst_pc)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_req) imem_rdata <= {2'b00, imem_addr[31:2]};
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Reference stream: after a (re)start, PCs ascend by 4 with 32-bit wrap.
    function automatic void load(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 400; i++) exp_q.push_back(start + 32'(i * 4));
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            occ = 0;
        end else if (redirect_valid) begin
            chk("redir_valid_low", {31'b0, inst_valid}, 32'd0);
            chk("redir_no_req", {31'b0, imem_req}, 32'd0);
            occ = 0;
        end else begin
            if (imem_req) begin
                occ++;
                chk("addr_align", {30'b0, imem_addr[1:0]}, 32'd0);
            end
            if (inst_valid && inst_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_empty got_pc=%h", inst_pc);
                end else begin
                    m_exp = exp_q.pop_front();
                    chk("pc", inst_pc, m_exp);
                    chk("data", inst_data, {2'b00, m_exp[31:2]});
                end
                occ--;
            end
            if (imem_req) chk("credit", {31'b0, occ <= DEPTH}, 32'd1);
        end
    end

    task automatic do_reset(input logic rdy);
        redirect_valid = 1'b0;
        inst_ready = rdy;
        rst_n = 1'b0;
        load(RESET_PC);
        @(posedge clk);
        #1;
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, RESET_PC);
        chk("rst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_data", inst_data, 32'd0);
        chk("rst_pc", inst_pc, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic latency_check();
        @(negedge clk);
        chk("lat_e0_valid", {31'b0, inst_valid}, 32'd0);
        @(negedge clk);
        chk("lat_e1_valid", {31'b0, inst_valid}, 32'd0);
        @(negedge clk);
        chk("lat_e2_valid", {31'b0, inst_valid}, 32'd1);
        chk("lat_e2_pc", inst_pc, RESET_PC);
`ifdef IFETCH_STATS_EN
        chk("stall_cnt", stall_cnt, 32'd3);
`endif
    endtask

    task automatic redirect(input logic [31:0] tgt);
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc = tgt;
        load(tgt & ~32'h3);
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        repeat (n - 1) @(posedge clk);
    endtask

    initial begin
        int n;
        bit seen;

        // Startup latency and sustained one-per-cycle stream
        do_reset(1'b1);
        latency_check();
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (inst_valid) n++;
        end
        chk("throughput", n, 32'd10);

        // Redirect while the read of 0x10 is in flight
        do_reset(1'b1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (imem_req && imem_addr == 32'h10) seen = 1'b1;
        end
        chk("see_req_10", {31'b0, seen}, 32'd1);
        redirect(32'h106);
        idle(1);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (inst_valid) seen = 1'b1;
        end
        chk("redir_seen", {31'b0, seen}, 32'd1);
        chk("redir_target", inst_pc, 32'h104);

        // Redirect while a pop would otherwise happen, then back-to-back
        repeat (4) @(negedge clk);
        chk("pre_redir_valid", {31'b0, inst_valid}, 32'd1);
        redirect(32'h200);
        idle(6);
        redirect(32'h300);
        redirect(32'h400);
        idle(6);

        // PC wrap
        redirect(32'hFFFF_FFFF);
        idle(8);

        // Full queue parks with no further requests
        do_reset(1'b0);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (imem_req) n++;
        end
        chk("full_reqs", n, 32'd4);
        chk("full_req_low", {31'b0, imem_req}, 32'd0);
        chk("full_head_pc", inst_pc, 32'd0);
        @(posedge clk);
        #1;
        inst_ready = 1'b1;
        repeat (10) @(posedge clk);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            inst_ready = ($urandom_range(9) < 7);
            if ($urandom_range(19) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc = ($urandom_range(3) == 0)
                    ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                    : $urandom;
                load(redirect_pc & ~32'h3);
            end else begin
                redirect_valid = 1'b0;
            end
        end
        idle(4);

        // Asynchronous reset mid-stream
        inst_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_valid", {31'b0, inst_valid}, 32'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_valid", {31'b0, inst_valid}, 32'd0);
        chk("async_req", {31'b0, imem_req}, 32'd0);
        chk("async_addr", imem_addr, RESET_PC);
        do_reset(1'b1);
        latency_check();
        repeat (6) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
